wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback logic for the 32-bit MIPS datapath. Sits between the data-memory stage and the register file write port.
- Captures MEM results each cycle and selects the writeback value (ALU result, aligned load data, or link address).
- Drives the register file's wr/addr3/data3 directly.
- Also supplies WB-to-ID forwarding data so that ID reads never see stale values.

---
 rtl/mips_pkg.sv | 15 +
 rtl/load_align.sv | 35 +++
 rtl/wb_stage.sv | 112 +++++++++++
 tb/tb_wb_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: writeback selects, load encodings, default widths.
package mips_pkg;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
endpackage

// File: rtl/load_align.sv
// Little-endian byte/half extraction and sign/zero extension of a raw memory word.
module load_align
    import mips_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] i_word,
    input  logic [1:0]    i_addr_lo,
    input  logic [2:0]    i_load_type,
    output logic [DW-1:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Misaligned halves (addr_lo[0]=1) silently use the half picked by addr_lo[1].
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_load_type)
            LD_LB:   o_data = {{(DW-8){w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {{(DW-8){1'b0}}, w_byte};
            LD_LH:   o_data = {{(DW-16){w_half[15]}}, w_half};
            LD_LHU:  o_data = {{(DW-16){1'b0}}, w_half};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback mux, register-file write port, WB->ID forwarding
// and retired-instruction counter.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int SUPPRESS_R0 = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_load_type,
    input  logic [1:0]       in_addr_lo,
    input  logic [AW-1:0]    in_dest,
    input  logic [DW-1:0]    in_alu_result,
    input  logic [DW-1:0]    in_mem_data,
    input  logic [DW-1:0]    in_pc_plus8,
    input  logic [AW-1:0]    id_addr1,
    input  logic [AW-1:0]    id_addr2,
    output logic             wr,
    output logic [AW-1:0]    addr3,
    output logic [DW-1:0]    data3,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [DW-1:0]    fwd_data1,
    output logic [DW-1:0]    fwd_data2,
    output logic [CNT_W-1:0] retired
);
    logic             r_valid;
    logic             r_reg_write;
    logic [1:0]       r_wb_sel;
    logic [2:0]       r_load_type;
    logic [1:0]       r_addr_lo;
    logic [AW-1:0]    r_dest;
    logic [DW-1:0]    r_alu;
    logic [DW-1:0]    r_mem;
    logic [DW-1:0]    r_pc8;
    logic [CNT_W-1:0] r_retired;

    logic [DW-1:0]    w_load;
    logic [DW-1:0]    w_wb_data;
    logic             w_r0_block;
    logic             w_wr;

    // Stall beats flush; a flush arriving during a stall is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wb_sel    <= '0;
            r_load_type <= '0;
            r_addr_lo   <= '0;
            r_dest      <= '0;
            r_alu       <= '0;
            r_mem       <= '0;
            r_pc8       <= '0;
            r_retired   <= '0;
        end else if (!stall) begin
            if (r_valid)
                r_retired <= r_retired + CNT_W'(1);
            if (flush) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
            end else begin
                r_valid     <= in_valid;
                r_reg_write <= in_reg_write;
                r_wb_sel    <= in_wb_sel;
                r_load_type <= in_load_type;
                r_addr_lo   <= in_addr_lo;
                r_dest      <= in_dest;
                r_alu       <= in_alu_result;
                r_mem       <= in_mem_data;
                r_pc8       <= in_pc_plus8;
            end
        end
    end

    load_align #(.DW(DW)) u_load_align (
        .i_word      (r_mem),
        .i_addr_lo   (r_addr_lo),
        .i_load_type (r_load_type),
        .o_data      (w_load)
    );

    always_comb begin
        case (r_wb_sel)
            WB_SEL_LOAD: w_wb_data = w_load;
            WB_SEL_LINK: w_wb_data = r_pc8;
            default:     w_wb_data = r_alu;
        endcase
    end

    assign w_r0_block = (SUPPRESS_R0 != 0) && (r_dest == '0);
    assign w_wr       = r_valid && r_reg_write && !w_r0_block;

    assign wr      = w_wr;
    assign addr3   = r_dest;
    assign data3   = w_wb_data;
    assign retired = r_retired;

    // Same-cycle bypass: the register file has no write-before-read.
    assign fwd_hit1  = w_wr && (id_addr1 == r_dest);
    assign fwd_hit2  = w_wr && (id_addr2 == r_dest);
    assign fwd_data1 = fwd_hit1 ? w_wb_data : '0;
    assign fwd_data2 = fwd_hit2 ? w_wb_data : '0;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues expectations, negedge monitor checks them.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, in_valid, in_reg_write;
    logic [1:0]  in_wb_sel, in_addr_lo;
    logic [2:0]  in_load_type;
    logic [4:0]  in_dest, id_addr1, id_addr2;
    logic [31:0] in_alu_result, in_mem_data, in_pc_plus8;

    logic        wr, fwd_hit1, fwd_hit2;
    logic [4:0]  addr3;
    logic [31:0] data3, fwd_data1, fwd_data2, retired;
    logic        wr_b, fwd_hit1_b, fwd_hit2_b;
    logic [4:0]  addr3_b;
    logic [31:0] data3_b, fwd_data1_b, fwd_data2_b;
    logic [3:0]  retired_b;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_load_type(in_load_type), .in_addr_lo(in_addr_lo), .in_dest(in_dest),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus8(in_pc_plus8),
        .id_addr1(id_addr1), .id_addr2(id_addr2),
        .wr(wr), .addr3(addr3), .data3(data3), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .retired(retired)
    );

    wb_stage #(.SUPPRESS_R0(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_load_type(in_load_type), .in_addr_lo(in_addr_lo), .in_dest(in_dest),
        .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus8(in_pc_plus8),
        .id_addr1(id_addr1), .id_addr2(id_addr2),
        .wr(wr_b), .addr3(addr3_b), .data3(data3_b), .fwd_hit1(fwd_hit1_b), .fwd_hit2(fwd_hit2_b),
        .fwd_data1(fwd_data1_b), .fwd_data2(fwd_data2_b), .retired(retired_b)
    );

    typedef struct {
        int          cyc;
        string       nm;
        bit          c_ad;
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
        bit          c_fwd;
        logic        h1, h2;
        logic [31:0] f1, f2;
        bit          c_b;
        logic        wr_b;
        logic [31:0] d_b;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tcyc = 0;
    bit          mv = 1'b0;
    logic [31:0] mret = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                exp_t e;
                e = q[i];
                chk({e.nm, ".wr"}, wr, e.wr);
                chk({e.nm, ".retired"}, retired, e.ret);
                chk({e.nm, ".retired_b"}, retired_b, e.ret[3:0]);
                if (e.c_ad) begin
                    chk({e.nm, ".addr3"}, addr3, e.a);
                    chk({e.nm, ".data3"}, data3, e.d);
                end
                if (e.c_fwd) begin
                    chk({e.nm, ".hit1"}, fwd_hit1, e.h1);
                    chk({e.nm, ".fdata1"}, fwd_data1, e.f1);
                    chk({e.nm, ".hit2"}, fwd_hit2, e.h2);
                    chk({e.nm, ".fdata2"}, fwd_data2, e.f2);
                end
                if (e.c_b) begin
                    chk({e.nm, ".wr_b"}, wr_b, e.wr_b);
                    chk({e.nm, ".data3_b"}, data3_b, e.d_b);
                end
                q.delete(i);
            end
        end
    end

    // Drives one capture cycle and advances the retired-count model.
    task automatic drv(input logic v, input logic rw, input logic [1:0] sel, input logic [2:0] lt,
                       input logic [1:0] lo, input logic [4:0] dst, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc8, input logic [4:0] a1,
                       input logic [4:0] a2, input logic st, input logic fl);
        @(negedge clk);
        #1;
        in_valid = v; in_reg_write = rw; in_wb_sel = sel; in_load_type = lt; in_addr_lo = lo;
        in_dest = dst; in_alu_result = alu; in_mem_data = mem; in_pc_plus8 = pc8;
        id_addr1 = a1; id_addr2 = a2; stall = st; flush = fl;
        if (!st) begin
            if (mv) mret = mret + 32'd1;
            mv = fl ? 1'b0 : v;
        end
        tcyc = cyc + 1;
    endtask

    task automatic ex(input string nm, input bit c_ad, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input bit c_fwd, input logic h1, input logic [31:0] f1,
                      input logic h2, input logic [31:0] f2);
        exp_t e;
        e.cyc = tcyc; e.nm = nm; e.c_ad = c_ad; e.wr = w; e.a = a; e.d = d;
        e.c_fwd = c_fwd; e.h1 = h1; e.f1 = f1; e.h2 = h2; e.f2 = f2;
        e.c_b = 1'b0; e.wr_b = 1'b0; e.d_b = '0; e.ret = mret;
        q.push_back(e);
    endtask

    task automatic idle();
        drv(0, 0, 2'b00, 3'b000, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic ld(input string nm, input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] x);
        drv(1, 1, 2'b01, lt, lo, 5'd2, 32'hDEAD_0000, 32'h80FF_7F01, 32'h0, 5'd0, 5'd2, 0, 0);
        ex(nm, 1, 1, 5'd2, x, 1, 0, 32'h0, 1, x);
    endtask

    initial begin
        stall = 0; flush = 0; in_valid = 0; in_reg_write = 0; in_wb_sel = 0; in_load_type = 0;
        in_addr_lo = 0; in_dest = 0; in_alu_result = 0; in_mem_data = 0; in_pc_plus8 = 0;
        id_addr1 = 0; id_addr2 = 0;
        #12;
        chk("rst.wr", wr, 0);
        chk("rst.addr3", addr3, 0);
        chk("rst.data3", data3, 0);
        chk("rst.hit1", fwd_hit1, 0);
        chk("rst.fdata2", fwd_data2, 0);
        chk("rst.retired", retired, 0);
        @(negedge clk); #1; rst = 0;

        drv(1, 1, 2'b00, 3'b000, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 5'd9, 0, 0);
        ex("alu", 1, 1, 5'd5, 32'h0000_1234, 1, 1, 32'h0000_1234, 0, 32'h0);

        ld("lb0",   3'b011, 2'd0, 32'h0000_0001);
        ld("lb3",   3'b011, 2'd3, 32'hFFFF_FF80);
        ld("lbu2",  3'b100, 2'd2, 32'h0000_00FF);
        ld("lh2",   3'b001, 2'd2, 32'hFFFF_80FF);
        ld("lhu0",  3'b010, 2'd0, 32'h0000_7F01);
        ld("lw",    3'b000, 2'd0, 32'h80FF_7F01);
        ld("lh1",   3'b001, 2'd1, 32'h0000_7F01);
        ld("lhu3",  3'b010, 2'd3, 32'h0000_80FF);
        ld("ldrsv", 3'b111, 2'd1, 32'h80FF_7F01);

        drv(1, 1, 2'b11, 3'b000, 2'b00, 5'd3, 32'h0000_ABCD, 32'h1111_1111, 32'h44, 5'd3, 5'd3, 0, 0);
        ex("sel11", 1, 1, 5'd3, 32'h0000_ABCD, 1, 1, 32'h0000_ABCD, 1, 32'h0000_ABCD);

        drv(1, 1, 2'b10, 3'b000, 2'b00, 5'd0, 32'h9, 32'h0, 32'h40, 5'd0, 5'd0, 0, 0);
        ex("r0", 1, 0, 5'd0, 32'h40, 1, 0, 32'h0, 0, 32'h0);
        q[q.size()-1].c_b = 1'b1; q[q.size()-1].wr_b = 1'b1; q[q.size()-1].d_b = 32'h40;

        drv(1, 0, 2'b00, 3'b000, 2'b00, 5'd4, 32'h4, 32'h0, 32'h0, 5'd4, 5'd4, 0, 0);
        ex("norw", 1, 0, 5'd4, 32'h4, 1, 0, 32'h0, 0, 32'h0);
        drv(0, 1, 2'b00, 3'b000, 2'b00, 5'd6, 32'h6, 32'h0, 32'h0, 5'd6, 5'd6, 0, 0);
        ex("novld", 1, 0, 5'd6, 32'h6, 1, 0, 32'h0, 0, 32'h0);

        drv(1, 1, 2'b00, 3'b000, 2'b00, 5'd7, 32'h77, 32'h0, 32'h0, 5'd7, 5'd0, 0, 0);
        ex("cap7", 1, 1, 5'd7, 32'h77, 1, 1, 32'h77, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 2'b00, 3'b000, 2'b00, 5'd9, 32'h99, 32'h0, 32'h0, 5'd9, 5'd7, 1, 0);
            ex("stall", 1, 1, 5'd7, 32'h77, 1, 0, 32'h0, 1, 32'h77);
        end
        drv(1, 1, 2'b00, 3'b000, 2'b00, 5'd10, 32'hA, 32'h0, 32'h0, 5'd7, 5'd0, 1, 1);
        ex("stfl", 1, 1, 5'd7, 32'h77, 1, 1, 32'h77, 0, 32'h0);
        drv(1, 1, 2'b00, 3'b000, 2'b00, 5'd11, 32'hB, 32'h0, 32'h0, 5'd7, 5'd11, 0, 1);
        ex("flush", 0, 0, 5'd0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        drv(1, 1, 2'b00, 3'b000, 2'b00, 5'd12, 32'h55, 32'h0, 32'h0, 5'd12, 5'd0, 0, 0);
        ex("cap12", 1, 1, 5'd12, 32'h55, 1, 1, 32'h55, 0, 32'h0);
        drv(0, 0, 2'b00, 3'b000, 2'b00, 5'd1, 32'h1, 32'h0, 32'h0, 5'd12, 5'd0, 1, 0);
        ex("hold12", 1, 1, 5'd12, 32'h55, 0, 0, 32'h0, 0, 32'h0);

        // Asynchronous reset mid-stall, between clock edges.
        @(negedge clk); #3;
        rst = 1;
        #1;
        chk("arst.wr", wr, 0);
        chk("arst.addr3", addr3, 0);
        chk("arst.data3", data3, 0);
        chk("arst.retired", retired, 0);
        chk("arst.retired_b", retired_b, 0);
        chk("arst.hit1", fwd_hit1, 0);
        @(negedge clk); #1;
        stall = 0; rst = 0; mv = 1'b0; mret = '0;

        for (int i = 0; i < 17; i++) begin
            drv(1, 1, 2'b00, 3'b000, 2'b00, 5'(i + 1), 32'(i * 3), 32'h0, 32'h0, 5'd0, 5'd0, 0, 0);
            ex("cnt", 1, 1, 5'(i + 1), 32'(i * 3), 0, 0, 32'h0, 0, 32'h0);
        end
        idle(); ex("cnt.end", 0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        idle(); ex("cnt.hold", 0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
